victim_cache: RTL
=================

Name: victim_cache

Overview:
- Small fully-associative victim cache between the L1 caches and L2.
- Holds clean or dirty lines evicted by the icache or dcache.
- Answers a one-cycle lookup on the L1 request path and swaps hit lines back into L1.
- Lines displaced from the victim cache are written back to L2 through a one-entry writeback buffer when dirty, and dropped when clean.

Parameters:
ENTRIES, 4, number of fully-associative line entries (power of 2, ≥2)
LINE_W, 128, line width in bits (16-byte block)
ADDR_W, 32, byte address width; tag = addr[ADDR_W-1:4]

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
lookup_valid_i  in  1  L1 request lookup strobe
lookup_addr_i  in  ADDR_W  lookup byte address; bits [3:0] ignored
evict_valid_i  in  1  L1 eviction insert strobe
evict_ready_o  out  1  insert accepted when high
evict_addr_i  in  ADDR_W  evicted line address; bits [3:0] ignored
evict_data_i  in  LINE_W  evicted line data
evict_dirty_i  in  1  evicted line dirty
result_valid_o  out  1  lookup result valid, one cycle after lookup
hit_o  out  1  lookup hit, qualified by result_valid_o
miss_o  out  1  lookup miss, qualified by result_valid_o
result_addr_o  out  ADDR_W  hit line address, {tag,4'b0}
result_data_o  out  LINE_W  hit line data
result_dirty_o  out  1  hit line dirty bit
wb_valid_o  out  1  dirty displaced line pending to L2
wb_ready_i  in  1  L2 accepts writeback
wb_addr_o  out  ADDR_W  writeback address, {tag,4'b0}
wb_data_o  out  LINE_W  writeback data

Behaviour:
- Reset: all entry valid bits 0, FIFO pointer 0, wb buffer empty. All outputs 0 except evict_ready_o, which is 1.
- Lookup:
  - In cycle T with lookup_valid_i=1, the tag is compared against all valid entries' pre-update contents.
  - In cycle T+1: result_valid_o=1, and exactly one of hit_o or miss_o is 1.
  - On hit, result_addr/data/dirty come from the matching entry. On miss, the data outputs are 0.
  - In cycles with no lookup, result_valid_o, hit_o and miss_o are 0.
- Hit = swap: the hit entry is invalidated at the end of cycle T. The line moves back to L1.
- Insert: accepted when evict_valid_i and evict_ready_o are both high in cycle T; the entry is written at the end of T. Slot priority:
  - (a) Matching valid tag: overwrite in place. dirty = old dirty OR new dirty.
  - (b) Same-cycle lookup hit: use the hit slot. This completes the swap; the pointer is not advanced.
  - (c) Lowest-index invalid entry.
  - (d) Entry at the FIFO pointer, which is displaced. The pointer then increments mod ENTRIES.
- Displacement:
  - A displaced dirty entry is loaded into the wb buffer in the same edge.
  - A displaced clean entry is dropped.
  - An entry invalidated by a hit in the same cycle counts as invalid for (c).
- Writeback buffer:
  - wb_valid_o stays high, with wb_addr_o/wb_data_o stable, until wb_ready_i=1 is seen on a clock edge.
  - Buffer empties the cycle after acceptance. A new load in the accept cycle is permitted: the buffer stays full with the new line.
- Backpressure:
  - evict_ready_o=0 only when case (d) applies, the pointer entry is dirty, and the wb buffer is full and not being drained this cycle (wb_ready_i=0).
  - evict_ready_o is combinational from the current state and inputs.
  - A rejected insert leaves the state unchanged; the source holds its data.
- Lookup is never stalled.
- Lookup and evict to the same line in the same cycle: lookup sees the old contents, so it reports a miss if the line is absent; the insert still completes.
- Reset mid-operation: all contents and any pending writeback are discarded immediately (asynchronously).

Test Plan:
- After reset: lookup 0x0000_1000 → T+1: result_valid_o=1, miss_o=1, hit_o=0, result_data_o=0; evict_ready_o=1.
- Insert 0x1000 data 0xA5..A5 clean, then lookup 0x1004 next cycle → T+1: hit_o=1, result_addr_o=0x1000, result_data_o=0xA5..A5, result_dirty_o=0. Repeat the lookup → miss (entry invalidated).
- Fill 4 entries: 0x1000, 0x2000, 0x3000 clean; 0x4000 dirty placed at pointer slot 0 via refill. Insert 0x5000 → slot 0 displaced, wb_valid_o=1, wb_addr_o=0x4000; hold wb_ready_i=0 for 3 cycles → outputs stable; pulse wb_ready_i=1 → wb_valid_o=0 next cycle.
- wb buffer full, wb_ready_i=0, pointer entry dirty, insert 0x6000 → evict_ready_o=0, contents unchanged; raise wb_ready_i → insert accepted the same cycle, new dirty line loaded into the buffer.
- Same-cycle lookup hit on 0x2000 plus insert of 0x7000 with all entries valid → 0x7000 occupies the former 0x2000 slot, FIFO pointer unchanged, no writeback.
- Assert rst_ni low while wb_valid_o=1 → wb_valid_o=0 immediately; a subsequent lookup of any prior address misses.

Source files
------------

// File: rtl/victim_cache_if.sv
// Bundles the victim cache's L1 lookup, L1 eviction and L2 writeback signals.
// The master modport is the L1/L2 side; the slave modport is the victim cache.
interface victim_cache_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              lookup_valid_i;
    logic [ADDR_W-1:0] lookup_addr_i;
    logic              evict_valid_i;
    logic              evict_ready_o;
    logic [ADDR_W-1:0] evict_addr_i;
    logic [LINE_W-1:0] evict_data_i;
    logic              evict_dirty_i;
    logic              result_valid_o;
    logic              hit_o;
    logic              miss_o;
    logic [ADDR_W-1:0] result_addr_o;
    logic [LINE_W-1:0] result_data_o;
    logic              result_dirty_o;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [LINE_W-1:0] wb_data_o;

    // Handshakes: an insert transfers on a cycle where evict_valid_i && evict_ready_o;
    // a writeback transfers on a cycle where wb_valid_o && wb_ready_i. Lookups are never stalled.
    modport slave (
        input  lookup_valid_i, lookup_addr_i,
        input  evict_valid_i, evict_addr_i, evict_data_i, evict_dirty_i,
        output evict_ready_o,
        output result_valid_o, hit_o, miss_o, result_addr_o, result_data_o, result_dirty_o,
        output wb_valid_o, wb_addr_o, wb_data_o,
        input  wb_ready_i
    );

    modport master (
        output lookup_valid_i, lookup_addr_i,
        output evict_valid_i, evict_addr_i, evict_data_i, evict_dirty_i,
        input  evict_ready_o,
        input  result_valid_o, hit_o, miss_o, result_addr_o, result_data_o, result_dirty_o,
        input  wb_valid_o, wb_addr_o, wb_data_o,
        output wb_ready_i
    );
endinterface

// File: rtl/victim_cache.sv
// Fully-associative victim cache between L1 and L2: one-cycle lookup with swap-on-hit,
// FIFO replacement, and a one-entry writeback buffer for displaced dirty lines.
module victim_cache #(
    parameter int ENTRIES = 4,
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    victim_cache_if.slave  bus
);
    localparam int TAG_W = ADDR_W - 4;
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_dirty;
    logic [TAG_W-1:0]   r_tag  [ENTRIES];
    logic [LINE_W-1:0]  r_data [ENTRIES];
    logic [IDX_W-1:0]   r_ptr;

    logic               r_wb_valid;
    logic [ADDR_W-1:0]  r_wb_addr;
    logic [LINE_W-1:0]  r_wb_data;

    logic               r_res_valid;
    logic               r_res_hit;
    logic               r_res_dirty;
    logic [ADDR_W-1:0]  r_res_addr;
    logic [LINE_W-1:0]  r_res_data;

    logic [TAG_W-1:0]   w_lk_tag;
    logic [TAG_W-1:0]   w_ev_tag;
    logic               w_lk_hit;
    logic [IDX_W-1:0]   w_lk_idx;
    logic               w_ev_match;
    logic [IDX_W-1:0]   w_ev_idx;
    logic [ENTRIES-1:0] w_valid_eff;
    logic               w_free;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_slot;
    logic               w_new_dirty;
    logic               w_case_d;
    logic               w_need_wb;
    logic               w_accept;
    logic               w_unused;

    assign w_lk_tag = bus.lookup_addr_i[ADDR_W-1:4];
    assign w_ev_tag = bus.evict_addr_i[ADDR_W-1:4];
    assign w_unused = ^{bus.lookup_addr_i[3:0], bus.evict_addr_i[3:0]};

    // Tag search on pre-update contents; the hit slot already counts as free for insertion.
    always_comb begin
        w_lk_hit    = 1'b0;
        w_lk_idx    = '0;
        w_ev_match  = 1'b0;
        w_ev_idx    = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        w_valid_eff = r_valid;
        for (int i = 0; i < ENTRIES; i++) begin
            if (bus.lookup_valid_i && r_valid[i] && (r_tag[i] == w_lk_tag)) begin
                w_lk_hit = 1'b1;
                w_lk_idx = IDX_W'(i);
            end
            if (r_valid[i] && (r_tag[i] == w_ev_tag)) begin
                w_ev_match = 1'b1;
                w_ev_idx   = IDX_W'(i);
            end
        end
        if (w_lk_hit) begin
            w_valid_eff[w_lk_idx] = 1'b0;
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!w_valid_eff[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_slot      = r_ptr;
        w_new_dirty = bus.evict_dirty_i;
        w_case_d    = 1'b0;
        if (w_ev_match) begin
            w_slot      = w_ev_idx;
            w_new_dirty = r_dirty[w_ev_idx] | bus.evict_dirty_i;
        end else if (w_lk_hit) begin
            w_slot = w_lk_idx;
        end else if (w_free) begin
            w_slot = w_free_idx;
        end else begin
            w_case_d = 1'b1;
        end
    end

    assign w_need_wb         = w_case_d & r_dirty[r_ptr];
    assign bus.evict_ready_o = !(w_need_wb && r_wb_valid && !bus.wb_ready_i);
    assign w_accept          = bus.evict_valid_i & bus.evict_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_ptr   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_lk_hit) begin
                r_valid[w_lk_idx] <= 1'b0;
            end
            if (w_accept) begin
                r_valid[w_slot] <= 1'b1;
                r_dirty[w_slot] <= w_new_dirty;
                r_tag[w_slot]   <= w_ev_tag;
                r_data[w_slot]  <= bus.evict_data_i;
                if (w_case_d) begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

    // A load in the drain cycle keeps the buffer full with the newer line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else if (w_accept && w_need_wb) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= {r_tag[r_ptr], 4'b0000};
            r_wb_data  <= r_data[r_ptr];
        end else if (bus.wb_ready_i) begin
            r_wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_dirty <= 1'b0;
            r_res_addr  <= '0;
            r_res_data  <= '0;
        end else begin
            r_res_valid <= bus.lookup_valid_i;
            r_res_hit   <= w_lk_hit;
            r_res_dirty <= w_lk_hit & r_dirty[w_lk_idx];
            r_res_addr  <= w_lk_hit ? {r_tag[w_lk_idx], 4'b0000} : '0;
            r_res_data  <= w_lk_hit ? r_data[w_lk_idx] : '0;
        end
    end

    assign bus.result_valid_o = r_res_valid;
    assign bus.hit_o          = r_res_valid & r_res_hit;
    assign bus.miss_o         = r_res_valid & ~r_res_hit;
    assign bus.result_dirty_o = r_res_dirty;
    assign bus.result_addr_o  = r_res_addr;
    assign bus.result_data_o  = r_res_data;
    assign bus.wb_valid_o     = r_wb_valid;
    assign bus.wb_addr_o      = r_wb_addr;
    assign bus.wb_data_o      = r_wb_data;
endmodule
